// File: rtl/uart_pkt_rx_if.sv
// Byte-stream and status bundle for the UART packet framer.
//   in_*        : received byte stream from the UART receiver (valid/ready)
//   out_*       : payload byte stream to the command layer (valid/ready, last marker)
//   frm_*/err_* : one-cycle per-frame status pulses
// master : byte source / payload sink / status observer (UART side plus command layer)
// slave  : the framer itself
interface uart_pkt_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_last;
    logic                 frm_done;
    logic                 frm_ok;
    logic                 err_len;
    logic                 err_chk;
    logic                 err_timeout;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last,
        input  frm_done, frm_ok, err_len, err_chk, err_timeout
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last,
        output frm_done, frm_ok, err_len, err_chk, err_timeout
    );
endinterface

// File: rtl/uart_pkt_rx.sv
// Frame extractor sitting behind the UART receiver.
// Parses [SOF][LEN][PAYLOAD x LEN][CHK] with CHK = XOR(LEN, payload bytes), streams the
// payload with a last marker and reports per-frame status pulses.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : uart_pkt_rx_if.slave -- in_* byte stream, out_* payload stream, frm_*/err_* status
module uart_pkt_rx #(
    parameter int unsigned          DATA_BITS    = 8,
    parameter logic [DATA_BITS-1:0] SOF_BYTE     = 8'hA5,
    parameter int unsigned          MAX_LEN      = 64,
    parameter int unsigned          TIMEOUT_CLKS = 48000
) (
    input logic          clk,
    input logic          reset,
    uart_pkt_rx_if.slave bus
);

    localparam int unsigned RemW = $clog2(MAX_LEN + 1);
    localparam int unsigned TmoW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [DATA_BITS-1:0] MaxLenB = DATA_BITS'(MAX_LEN);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {StIdle, StLen, StPayload, StChk} state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] chk_q, chk_d;
    logic [RemW-1:0]      rem_q, rem_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic                 got_q, got_d;        // at least one payload byte accepted
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic                 frm_done_q, frm_done_d;
    logic                 frm_ok_q, frm_ok_d;
    logic                 err_len_q, err_len_d;
    logic                 err_chk_q, err_chk_d;
    logic                 err_tmo_q, err_tmo_d;

    logic in_ready;
    logic accept;
    logic stall;
    logic tmo_fire;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            StIdle, StLen: in_ready = 1'b1;
            StPayload:     in_ready = !out_valid_q || bus.out_ready;
            // Last payload byte must drain before the status for the frame appears.
            StChk:         in_ready = !out_valid_q;
            default:       in_ready = 1'b0;
        endcase
    end

    assign accept = bus.in_valid && in_ready;
    // Downstream stall is not sender idle, so the timeout holds.
    assign stall = out_valid_q && !bus.out_ready;
    assign tmo_fire = (state_q != StIdle) && !accept && !stall && (tmo_q == TmoLast);

    always_comb begin
        state_d     = state_q;
        chk_d       = chk_q;
        rem_d       = rem_q;
        tmo_d       = tmo_q;
        got_d       = got_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_last_d  = out_last_q && out_valid_d;
        out_data_d  = out_data_q;
        frm_done_d  = 1'b0;
        frm_ok_d    = 1'b0;
        err_len_d   = 1'b0;
        err_chk_d   = 1'b0;
        err_tmo_d   = 1'b0;

        if (state_q == StIdle || accept) begin
            tmo_d = '0;
        end else if (!stall) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (accept && bus.in_data == SOF_BYTE) begin
                    state_d = StLen;
                    chk_d   = '0;
                    got_d   = 1'b0;
                end
            end
            StLen: begin
                if (accept) begin
                    if (bus.in_data != '0 && bus.in_data <= MaxLenB) begin
                        chk_d   = bus.in_data;
                        rem_d   = RemW'(bus.in_data);
                        state_d = StPayload;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.in_data;
                    out_last_d  = (rem_q == RemW'(1));
                    chk_d       = chk_q ^ bus.in_data;
                    rem_d       = rem_q - 1'b1;
                    got_d       = 1'b1;
                    if (rem_q == RemW'(1)) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    frm_done_d = 1'b1;
                    frm_ok_d   = (bus.in_data == chk_q);
                    err_chk_d  = (bus.in_data != chk_q);
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // tmo_fire implies no acceptance this cycle, so nothing above is overridden.
        if (tmo_fire) begin
            state_d    = StIdle;
            tmo_d      = '0;
            err_tmo_d  = 1'b1;
            frm_done_d = got_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            chk_q       <= '0;
            rem_q       <= '0;
            tmo_q       <= '0;
            got_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            frm_done_q  <= 1'b0;
            frm_ok_q    <= 1'b0;
            err_len_q   <= 1'b0;
            err_chk_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            chk_q       <= chk_d;
            rem_q       <= rem_d;
            tmo_q       <= tmo_d;
            got_q       <= got_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            frm_done_q  <= frm_done_d;
            frm_ok_q    <= frm_ok_d;
            err_len_q   <= err_len_d;
            err_chk_q   <= err_chk_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_data    = out_data_q;
    assign bus.frm_done    = frm_done_q;
    assign bus.frm_ok      = frm_ok_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_chk     = err_chk_q;
    assign bus.err_timeout = err_tmo_q;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Self-checking bench for uart_pkt_rx: directed frames, expected payload/status pushed into
// queues by the stimulus and popped by an independent output monitor.
module tb_uart_pkt_rx;

    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    uart_pkt_rx_if #(.DATA_BITS(8)) bus ();

    uart_pkt_rx #(
        .DATA_BITS   (8),
        .SOF_BYTE    (8'hA5),
        .MAX_LEN     (64),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] exp_pay[$];   // {last, data}
    logic [4:0] exp_st[$];    // {frm_done, frm_ok, err_len, err_chk, err_timeout}
    logic [4:0] st;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(string name, logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endfunction

    function automatic void exp_p(logic [7:0] d, logic last);
        exp_pay.push_back({last, d});
    endfunction

    function automatic void exp_s(logic done, logic ok, logic len, logic chk, logic tmo);
        exp_st.push_back({done, ok, len, chk, tmo});
    endfunction

    // Output monitor: samples mid-cycle, well away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_pay.size() == 0) unexpected("payload", {bus.out_last, bus.out_data});
                    else check("payload", {bus.out_last, bus.out_data}, exp_pay.pop_front());
                end
                st = {bus.frm_done, bus.frm_ok, bus.err_len, bus.err_chk, bus.err_timeout};
                if (st != 5'b0) begin
                    if (exp_st.size() == 0) unexpected("status", st);
                    else check("status", st, exp_st.pop_front());
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        #1;
        while (!bus.in_ready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 500) begin
                n_vec++;
                n_err++;
                $display("FAIL send_stall: byte %0h not accepted within 500 cycles", b);
                $fatal(1, "send stalled");
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // First byte sits in the most significant used byte of v.
    task automatic send_seq(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(v[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic good_frame();
        exp_p(8'h11, 1'b0);
        exp_p(8'h22, 1'b0);
        exp_p(8'h33, 1'b1);
        exp_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // CHK = 03 ^ 11 ^ 22 ^ 33 = 03
        send_seq(128'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}), 6);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", {bus.out_valid, bus.out_last, bus.frm_done, bus.frm_ok, bus.err_len,
                             bus.err_chk, bus.err_timeout, bus.out_data}, 0);
        check("reset_in_ready", bus.in_ready, 1);
        reset = 1'b0;
        idle(2);

        // Good frame; status must appear the cycle after the CHK byte is accepted
        good_frame();
        #1;
        check("frm_done_timing", {bus.frm_done, bus.frm_ok}, 2'b11);
        idle(3);

        // Bad checksum, then a good frame back-to-back
        exp_p(8'h11, 1'b0);
        exp_p(8'h22, 1'b0);
        exp_p(8'h33, 1'b1);
        exp_s(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_seq(128'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04}), 6);
        good_frame();
        idle(3);

        // Length errors: LEN = 0 and LEN = 65
        exp_s(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_seq(128'({8'hA5, 8'h00}), 2);
        idle(2);
        good_frame();
        idle(2);
        exp_s(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_seq(128'({8'hA5, 8'h41}), 2);
        idle(2);
        good_frame();
        idle(2);

        // Garbage before SOF is dropped; CHK = 01 ^ 7E = 7F
        exp_p(8'h7E, 1'b1);
        exp_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_seq(128'({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F}), 7);
        idle(2);

        // Backpressure for 100 cycles mid-payload: no acceptance, stable data, no timeout
        exp_p(8'h11, 1'b0);
        exp_p(8'h22, 1'b0);
        exp_p(8'h33, 1'b1);
        exp_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_seq(128'({8'hA5, 8'h03, 8'h11}), 3);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h22;
        repeat (100) begin
            #1;
            check("bp_hold", {bus.in_ready, bus.out_valid, bus.out_data}, {1'b0, 1'b1, 8'h11});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        send_seq(128'({8'h22, 8'h33, 8'h03}), 3);
        idle(3);

        // Inter-byte timeout after one payload byte
        exp_p(8'h10, 1'b0);
        exp_s(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_seq(128'({8'hA5, 8'h02, 8'h10}), 3);
        idle(TMO + 8);
        exp_p(8'h7E, 1'b1);
        exp_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_seq(128'({8'hA5, 8'h01, 8'h7E, 8'h7F}), 4);
        idle(3);

        // Reset mid-payload: byte 01 is delivered; 02 is lost to the reset
        exp_p(8'h01, 1'b0);
        send_seq(128'({8'hA5, 8'h04, 8'h01, 8'h02}), 4);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outs", {bus.out_valid, bus.out_last, bus.frm_done, bus.frm_ok,
                                bus.err_len, bus.err_chk, bus.err_timeout, bus.out_data}, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        reset = 1'b0;
        idle(2);
        // CHK = 01 ^ 55 = 54
        exp_p(8'h55, 1'b1);
        exp_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_seq(128'({8'hA5, 8'h01, 8'h55, 8'h54}), 4);
        idle(TMO + 8);

        check("payload_left", exp_pay.size(), 0);
        check("status_left", exp_st.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
